apb_slv_regfile: RTL and testbench

Parametrised APB4 completer that owns a bank of software-visible control registers, with byte strobes, run-time programmable wait states, and slave-error signalling. It sits behind the AHB-to-APB bridge as a generic peripheral endpoint and replaces fixed-width, zero-wait register slaves. It is the RTL counterpart our APB slave VIP drives and monitors.

---
 rtl/apb_slv_regfile_pkg.sv | 14 +
 rtl/apb_slv_regfile_if.sv | 27 ++
 rtl/apb_slv_regfile_wait_ctr.sv | 50 +++++
 rtl/apb_slv_regfile.sv | 203 ++++++++++++++++++++
 tb/tb_apb_slv_regfile.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_regfile_pkg.sv
// Shared types and constants for the APB register-file completer.
// Used by apb_slv_regfile and apb_slv_wait_ctr.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_slv_state_e;

    localparam int APB_PROT_PRIV_BIT = 0;
    localparam int APB_WAIT_W        = 4;

endpackage

// File: rtl/apb_slv_regfile_if.sv
// APB4 bus bundle between requester (master) and completer (slave).
// pclk/preset travel as plain ports alongside it.
interface apb_slv_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, pstrb, paddr, pwdata, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pstrb, paddr, pwdata, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slv_regfile_wait_ctr.sv
// Wait-state counter: loads on setup, decrements in WAIT, flags the final cycle.
// last is combinational so a zero load can skip WAIT entirely.
module apb_slv_wait_ctr
    import apb_slv_pkg::*;
#(
    parameter int W = APB_WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic         last
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: load wins over clear, clear over decrement; never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // last looks at the incoming value during a load so stale counts cannot leak in
    always_comb begin
        if (load) begin
            last = (load_val == {W{1'b0}});
        end else begin
            last = (cnt_q == W'(1));
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/apb_slv_regfile.sv
// APB4 completer owning NUM_REGS software registers with byte strobes,
// programmable wait states and error response. Optional privilege check:
// define APB_SLV_REGFILE_PROT_CHECK_EN.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    PRIV_BASE  = NUM_REGS
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb_slv_regfile_if.slave               apb,
    input  logic [APB_WAIT_W-1:0]          wait_cycles,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_slv_state_e        state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
    logic                  priv_q, priv_d;
`endif
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic setup_s;
    logic ctr_load_s, ctr_dec_s, ctr_clr_s, ctr_last_s;
    logic err_nx_s, err_cur_s;

    function automatic logic oob_f(input logic [IDX_W-1:0] idx);
        return (32'(idx) >= 32'(NUM_REGS));
    endfunction

`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
    function automatic logic priv_err_f(input logic [IDX_W-1:0] idx, input logic priv);
        return (32'(idx) >= 32'(PRIV_BASE)) && !priv;
    endfunction
`endif

    assign setup_s = apb.psel & ~apb.penable;

    apb_slv_wait_ctr #(.W(APB_WAIT_W)) u_wait_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (ctr_load_s),
        .load_val (wait_cycles),
        .dec      (ctr_dec_s),
        .clr      (ctr_clr_s),
        .last     (ctr_last_s)
    );

    // wait counter control; a deselect in WAIT clears the pending count
    always_comb begin
        ctr_load_s = 1'b0;
        ctr_dec_s  = 1'b0;
        ctr_clr_s  = 1'b0;
        case (state_q)
            IDLE: ctr_load_s = setup_s;
            WAIT: begin
                if (!apb.psel) begin
                    ctr_clr_s = 1'b1;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end
            default: ctr_load_s = 1'b0;
        endcase
    end

    // next state and setup-phase capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
        priv_d  = priv_q;
`endif
        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    idx_d   = apb.paddr[ADDR_WIDTH-1:IDX_LSB];
                    write_d = apb.pwrite;
                    strb_d  = apb.pstrb;
                    wdata_d = apb.pwdata;
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
                    priv_d  = apb.pprot[APB_PROT_PRIV_BIT];
`endif
                    state_d = ctr_last_s ? DONE : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (ctr_last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // response is computed on entry to DONE so pready/pslverr/prdata come straight from flops
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = {DATA_WIDTH{1'b0}};
        err_nx_s  = oob_f(idx_d);
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
        err_nx_s  = err_nx_s | priv_err_f(idx_d, priv_d);
`endif
        if (state_d == DONE) begin
            pready_d  = 1'b1;
            pslverr_d = err_nx_s;
            if (!write_d && !err_nx_s) begin
                prdata_d = regs_q[idx_d[SEL_W-1:0]];
            end else begin
                prdata_d = {DATA_WIDTH{1'b0}};
            end
        end else begin
            pready_d = 1'b0;
        end
    end

    // strobe merge, committed on the DONE edge of an error-free write
    always_comb begin
        regs_d    = regs_q;
        err_cur_s = oob_f(idx_q);
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
        err_cur_s = err_cur_s | priv_err_f(idx_q, priv_q);
`endif
        if ((state_q == DONE) && write_q && !err_cur_s) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (strb_q[k]) begin
                    regs_d[idx_q[SEL_W-1:0]][8*k +: 8] = wdata_q[8*k +: 8];
                end else begin
                    regs_d[idx_q[SEL_W-1:0]][8*k +: 8] = regs_q[idx_q[SEL_W-1:0]][8*k +: 8];
                end
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // state, captured request, response and register bank
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            write_q   <= 1'b0;
            strb_q    <= {STRB_W{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
            priv_q    <= 1'b0;
`endif
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
            priv_q    <= priv_d;
`endif
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
endmodule

// File: tb/tb_apb_slv_regfile.sv
// Self-checking bench for apb_slv_regfile: directed cases plus randomized
// transfers against an array-based reference model.
module tb_apb_slv_regfile;
    localparam int          NR   = 16;
    localparam logic [31:0] RSTV = 32'hC0DE_0001;
`ifdef APB_SLV_REGFILE_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic            pclk;
    logic            preset;
    logic [3:0]      wait_cycles;
    logic [NR*32-1:0] reg_q;
    logic [31:0]     mdl [NR];
    int              n_checks = 0;
    int              n_errors = 0;

    apb_slv_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    apb_slv_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .NUM_REGS   (NR),
        .RESET_VAL  (RSTV),
        .PRIV_BASE  (8)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .apb         (bus),
        .wait_cycles (wait_cycles),
        .reg_q       (reg_q)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q[i*32 +: 32]), 64'(mdl[i]));
        end
    endtask

    function automatic bit exp_err(input int idx, input logic [2:0] prot);
        return (idx >= NR) || (PROT_EN && idx >= 8 && !prot[0]);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RSTV;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] w);
        int idx;
        int cyc;
        bit err;
        idx = int'(addr[11:2]);
        err = exp_err(idx, prot);
        @(posedge pclk); #1;
        chk("idle_pready", 64'(bus.pready), 64'd0);
        chk_regs("pre");
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pstrb   = strb;
        bus.pprot   = prot;
        wait_cycles = w;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        wait_cycles = 4'($urandom_range(0, 15));
        cyc = 1;
        while (!bus.pready && cyc < 40) begin
            chk("quiet_outputs", {31'd0, bus.pslverr, bus.prdata}, 64'd0);
            @(posedge pclk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(int'(w) + 1));
        chk("pslverr", 64'(bus.pslverr), 64'(err));
        if (!wr) begin
            chk("prdata", 64'(bus.prdata), err ? 64'd0 : 64'(mdl[idx]));
        end
        if (wr && !err && bus.pready) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) mdl[idx][8*k +: 8] = data[8*k +: 8];
            end
        end
    endtask

    task automatic abort_xfer(input logic [11:0] addr, input logic [31:0] data);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = addr; bus.pwdata = data; bus.pstrb = 4'hF; bus.pprot = 3'b001;
        wait_cycles = 4'd5;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            chk("abort_wait_pready", 64'(bus.pready), 64'd0);
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            chk("abort_pready", 64'(bus.pready), 64'd0);
        end
        chk_regs("abort");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        preset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 12'h000; bus.pwdata = 32'h0; bus.pstrb = 4'h0; bus.pprot = 3'b000;
        wait_cycles = 4'd0;
        mdl_reset();
        #2;
        chk("rst_pready", 64'(bus.pready), 64'd0);
        chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
        chk("rst_prdata", 64'(bus.prdata), 64'd0);
        chk_regs("rst");
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset = 1'b0;

        xfer(1'b1, 12'h008, 32'hA5A5_1234, 4'hF, 3'b001, 4'd0);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 4'd0);
        idle(2);
        xfer(1'b0, 12'h000, 32'h0, 4'hF, 3'b001, 4'd3);
        xfer(1'b1, 12'h008, 32'h1122_3344, 4'hF, 3'b001, 4'd1);
        xfer(1'b1, 12'h008, 32'hFFFF_FFFF, 4'b0101, 3'b001, 4'd0);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 4'd2);
        xfer(1'b1, 12'h00A, 32'h5555_AAAA, 4'h0, 3'b001, 4'd0);
        xfer(1'b0, 12'h008, 32'h0, 4'hF, 3'b001, 4'd0);
        xfer(1'b1, 12'h040, 32'h1234_5678, 4'hF, 3'b001, 4'd1);
        xfer(1'b0, 12'h040, 32'h0, 4'hF, 3'b001, 4'd0);
        xfer(1'b1, 12'h024, 32'hDEAD_BEEF, 4'hF, 3'b000, 4'd0);
        xfer(1'b0, 12'h024, 32'h0, 4'hF, 3'b000, 4'd0);
        xfer(1'b1, 12'h024, 32'hDEAD_BEEF, 4'hF, 3'b001, 4'd2);
        xfer(1'b0, 12'h024, 32'h0, 4'hF, 3'b001, 4'd0);
        abort_xfer(12'h008, 32'h0BAD_0BAD);
        xfer(1'b0, 12'h008, 32'h0, 4'hF, 3'b001, 4'd0);

        for (int n = 0; n < 300; n++) begin
            int          ridx;
            logic [11:0] raddr;
            ridx  = $urandom_range(0, NR + 3);
            raddr = 12'((ridx << 2) | $urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), raddr, 32'($urandom), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h00C; bus.pwdata = 32'h7777_8888; bus.pstrb = 4'hF; bus.pprot = 3'b001;
        wait_cycles = 4'd5;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #2;
        preset = 1'b1;
        mdl_reset();
        #1;
        chk("midrst_pready", 64'(bus.pready), 64'd0);
        chk("midrst_pslverr", 64'(bus.pslverr), 64'd0);
        chk("midrst_prdata", 64'(bus.prdata), 64'd0);
        chk_regs("midrst");
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        xfer(1'b0, 12'h00C, 32'h0, 4'hF, 3'b001, 4'd1);
        xfer(1'b0, 12'h008, 32'h0, 4'hF, 3'b001, 4'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
